// File: rtl/index_add_ctrl.sv
// ---------------------------------------------------------------------------
// index_add_ctrl
//
// Request-side controller and result buffer for a pipelined WIDTH-bit index
// adder. Operand requests are accepted on a valid/ready handshake and issued
// to the adder. A tag pipeline records which adder slots carry real operands.
// Each tagged sum is captured into a small result FIFO. Downstream
// back-pressure is therefore absorbed by the FIFO, and the adder never has to
// stall. Stalling would be harmful because dropping ce clears the adder's
// valid history.
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. The ready signals here depend only on registered state,
// so no combinational path runs from rsp_ready to req_ready.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   req_valid/req_ready  request handshake; req_a/req_b operands
//   adder_ce/a/b         drive the adder's ce, A and B inputs
//   adder_valid/adder_s  adder valid flag and sum outputs
//   rsp_valid/rsp_ready  response handshake; rsp_sum = (a+b) mod 2^WIDTH
//   rsp_carry            carry out of the addition (INDEX_ADD_CARRY_EN only)
//   busy                 at least one request is accepted but not yet popped
//   err                  sticky: a tagged slot emerged with adder_valid low
//
// Configuration macro: INDEX_ADD_CARRY_EN adds the rsp_carry port. It also
// builds a delay line for the A operand that is used to derive the carry.
// ---------------------------------------------------------------------------
module index_add_ctrl #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             adder_ce,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic             adder_valid,
    input  logic [WIDTH-1:0] adder_s,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
`ifdef INDEX_ADD_CARRY_EN
    output logic             rsp_carry,
`endif
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic                 ce_q, ce_d;
    logic [CNT_W-1:0]     occ_q, occ_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 issue_q, issue_d;
    logic [LATENCY-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fcnt_q, fcnt_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 pop;
    logic                 capture;

`ifdef INDEX_ADD_CARRY_EN
    logic [WIDTH-1:0]     adly_q [LATENCY];
    logic [WIDTH-1:0]     adly_d [LATENCY];
    logic                 cmem_q [DEPTH];
    logic                 cmem_d [DEPTH];
    logic                 cap_carry;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts every accepted request until it is popped. This bounds
    // the in-flight count plus the FIFO fill to DEPTH, so the FIFO can never
    // overflow.
    assign req_ready = ce_q && (occ_q < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (fcnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign capture   = tag_q[LATENCY-1];

    assign adder_ce  = ce_q;
    assign adder_a   = opa_q;
    assign adder_b   = opb_q;
    assign rsp_sum   = mem_q[rd_ptr_q];
    assign busy      = (occ_q != '0);
    assign err       = err_q;

`ifdef INDEX_ADD_CARRY_EN
    // The adder reduces modulo 2^WIDTH, so the sum wrapped exactly when the
    // result is smaller than an operand.
    assign cap_carry = (adder_s < adly_q[LATENCY-1]);
    assign rsp_carry = cmem_q[rd_ptr_q];
`endif

    always_comb begin
        ce_d     = 1'b1;
        occ_d    = occ_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        issue_d  = issue_q;
        tag_d    = tag_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        err_d    = err_q;

        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (accept) begin
            opa_d = req_a;
            opb_d = req_b;
        end

        // issue_q marks the cycle in which real operands sit on the adder
        // inputs. The adder samples them at the end of that cycle, so the tag
        // enters slot 0 one edge later. The tag then reaches slot LATENCY-1
        // in the same cycle that the matching sum is on adder_s.
        if (ce_q) begin
            issue_d = accept;
            for (int i = 1; i < LATENCY; i++) begin
                tag_d[i] = tag_q[i-1];
            end
            tag_d[0] = issue_q;
        end

        if (capture) begin
            mem_d[wr_ptr_q] = adder_s;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            err_d           = err_q | ~adder_valid;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({capture, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

`ifdef INDEX_ADD_CARRY_EN
    always_comb begin
        adly_d = adly_q;
        cmem_d = cmem_q;
        if (ce_q) begin
            for (int i = 1; i < LATENCY; i++) begin
                adly_d[i] = adly_q[i-1];
            end
            adly_d[0] = opa_q;
        end
        if (capture) begin
            cmem_d[wr_ptr_q] = cap_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                adly_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                cmem_q[i] <= 1'b0;
            end
        end else begin
            adly_q <= adly_d;
            cmem_q <= cmem_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_q     <= 1'b0;
            occ_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            issue_q  <= 1'b0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ce_q     <= ce_d;
            occ_q    <= occ_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            issue_q  <= issue_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
        end
    end

    // A capture into a full FIFO would mean the credit accounting is broken.
    assert property (@(posedge clk) disable iff (reset)
        !(capture && (fcnt_q == DEPTH_C)));

endmodule

// File: tb/tb_index_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_index_add_ctrl
//
// Self-checking bench for index_add_ctrl.
//
// The bench contains a behavioural adder with LAT pipeline stages. Its valid
// history clears whenever ce is low. An operand A equal to BAD_A marks that
// slot as emerging with adder_valid low.
//
// A reference model tracks the accepted requests in queues, in request order.
// Each entry records its sum, its carry, a bad-slot flag, and the cycle in
// which it may first appear on the response port: accept + LAT + 2.
// Occupancy is the queue length. adder_ce is high in a cycle when reset was
// low at the edge that started that cycle.
//
// Outputs are checked on every falling edge. The model advances on every
// rising edge.
// ---------------------------------------------------------------------------
module tb_index_add_ctrl;

    localparam int WIDTH = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] BAD_A = 16'hBAD0;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic             adder_ce;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_valid;
    logic [WIDTH-1:0] adder_s;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_sum;
`ifdef INDEX_ADD_CARRY_EN
    logic             rsp_carry;
`endif
    logic             busy;
    logic             err;

    index_add_ctrl #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .adder_ce    (adder_ce),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_valid (adder_valid),
        .adder_s     (adder_s),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_sum     (rsp_sum),
`ifdef INDEX_ADD_CARRY_EN
        .rsp_carry   (rsp_carry),
`endif
        .busy        (busy),
        .err         (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural adder ----------------
    logic [WIDTH-1:0] s_pipe [LAT];
    logic             v_pipe [LAT];
    logic             p_pipe [LAT];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                s_pipe[i] <= '0;
                v_pipe[i] <= 1'b0;
                p_pipe[i] <= 1'b0;
            end
        end else if (adder_ce) begin
            for (int i = 1; i < LAT; i++) begin
                s_pipe[i] <= s_pipe[i-1];
                v_pipe[i] <= v_pipe[i-1];
                p_pipe[i] <= p_pipe[i-1];
            end
            s_pipe[0] <= adder_a + adder_b;
            v_pipe[0] <= 1'b1;
            p_pipe[0] <= (adder_a == BAD_A);
        end else begin
            for (int i = 0; i < LAT; i++) begin
                v_pipe[i] <= 1'b0;
            end
        end
    end

    assign adder_s     = s_pipe[LAT-1];
    assign adder_valid = v_pipe[LAT-1] && !p_pipe[LAT-1];

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [WIDTH-1:0] exp_q [$];
    int               rdy_q [$];
    bit               bad_q [$];
    bit               cy_q  [$];
    int               cyc = 0;
    bit               ce_exp = 1'b0;
    bit               err_exp = 1'b0;
    logic [WIDTH-1:0] last_a = '0;
    logic [WIDTH-1:0] last_b = '0;

    // Values captured on the falling edge for use at the next rising edge.
    bit               rst_s = 1'b1;
    bit               acc_n = 1'b0;
    bit               pop_n = 1'b0;
    logic [WIDTH-1:0] acc_a = '0;
    logic [WIDTH-1:0] acc_b = '0;
    int               acc_cnt = 0;
    bit               rexp;
    bit               vexp;

    always @(negedge clk) begin
        rexp = ce_exp && (exp_q.size() < DEPTH);
        vexp = (exp_q.size() > 0) && (cyc >= rdy_q[0]);
        check_eq("req_ready", req_ready, rexp);
        check_eq("adder_ce", adder_ce, ce_exp);
        check_eq("adder_a", adder_a, last_a);
        check_eq("adder_b", adder_b, last_b);
        check_eq("rsp_valid", rsp_valid, vexp);
        check_eq("busy", busy, exp_q.size() != 0);
        check_eq("err", err, err_exp);
        if (vexp) begin
            check_eq("rsp_sum", rsp_sum, exp_q[0]);
`ifdef INDEX_ADD_CARRY_EN
            check_eq("rsp_carry", rsp_carry, cy_q[0]);
`endif
        end
        rst_s = reset;
        acc_n = req_valid && rexp;
        acc_a = req_a;
        acc_b = req_b;
        pop_n = vexp && rsp_ready;
        if (acc_n) acc_cnt++;
    end

    always @(posedge clk) begin
        logic [WIDTH:0] full_sum;
        cyc++;
        if (rst_s) begin
            exp_q.delete();
            rdy_q.delete();
            bad_q.delete();
            cy_q.delete();
            ce_exp  = 1'b0;
            err_exp = 1'b0;
            last_a  = '0;
            last_b  = '0;
        end else begin
            ce_exp = 1'b1;
            if (pop_n) begin
                void'(exp_q.pop_front());
                void'(rdy_q.pop_front());
                void'(bad_q.pop_front());
                void'(cy_q.pop_front());
            end
            if (acc_n) begin
                full_sum = {1'b0, acc_a} + {1'b0, acc_b};
                exp_q.push_back(full_sum[WIDTH-1:0]);
                cy_q.push_back(full_sum[WIDTH]);
                bad_q.push_back(acc_a == BAD_A);
                // Accepted in cycle (cyc-1); visible LAT+2 cycles later.
                rdy_q.push_back(cyc - 1 + LAT + 2);
                last_a = acc_a;
                last_b = acc_b;
            end
            for (int i = 0; i < bad_q.size(); i++) begin
                if (bad_q[i] && (cyc >= rdy_q[i])) err_exp = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = -1;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (req_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check_eq("send_accepted", done, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) done = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("drain_done", done, 1'b1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int seen;
        int base;
        bit got;
        logic [WIDTH-1:0] ra;

        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_rsp_sum", rsp_sum, 16'h0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_req_ready", req_ready, 1'b0);
        idle(3);

        // Single request: visible exactly LAT+2 cycles after acceptance.
        send(16'd3, 16'd4, k);
        seen = -1;
        for (int n = 0; n < 20 && seen < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cyc;
                check_eq("t1_sum", rsp_sum, 16'd7);
            end
        end
        check_eq("t1_latency", seen - k, LAT + 2);
        @(negedge clk);
        check_eq("t1_valid_once", rsp_valid, 1'b0);
        check_eq("t1_busy_off", busy, 1'b0);
        idle(1);

        // Back-to-back stream at full rate.
        for (int i = 0; i < 8; i++) send(WIDTH'(i), 16'd100, k);
        wait_idle();

        // Back-pressure: only DEPTH accepted while rsp_ready is low.
        rsp_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send(WIDTH'(10 + i), 16'd20, k);
            end
            begin
                idle(14);
                check_eq("t3_accepted", acc_cnt - base, DEPTH);
                rsp_ready = 1'b1;
            end
        join
        wait_idle();

        // Wrap-around and carry.
        send(16'hFFFF, 16'h0002, k);
        send(16'h0001, 16'h0001, k);
        send(16'h8000, 16'h8000, k);
        wait_idle();

        // Reset with requests in flight.
        for (int i = 0; i < 3; i++) send(WIDTH'(40 + i), 16'd1, k);
        pulse_reset();
        got = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check_eq("t5_no_stale_rsp", got, 1'b0);
        idle(1);
        send(16'd5, 16'd5, k);
        wait_idle();

        // Adder reports invalid at a tagged capture.
        send(BAD_A, 16'd1, k);
        wait_idle();
        idle(3);
        check_eq("t6_err_sticky", err, 1'b1);
        pulse_reset();
        @(negedge clk);
        check_eq("t6_err_cleared", err, 1'b0);
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            ra = WIDTH'($urandom_range(0, 65535));
            if (ra == BAD_A) ra = '0;
            req_valid = ($urandom_range(0, 99) < 70);
            req_a     = ra;
            req_b     = WIDTH'($urandom_range(0, 65535));
            rsp_ready = ($urandom_range(0, 99) < 60);
            idle(1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

endmodule
